// File: rtl/gate_encoder.sv
// -----------------------------------------------------------------------------
// gate_encoder
//
// Transmit side of the gate-definition byte stream. Latches one gate
// descriptor (type, input wire ids, garbled-table ciphertexts, output gate id)
// and serializes it into the CMD_GATES byte format that spi_decoder reads back.
// The output is a byte-wide valid/ready stream with first/last framing.
//
// Frame layout (multi-byte fields little-endian, id pad bits zero):
//   HDR  1 B  {6'b0, type}
//   ID1  2 B  first input wire id
//   ID2  2 B  second input wire id          (AND / XOR only)
//   CTXT 48 B ciphertext rows 1,2,3         (AND only; row 0 is implicit zero)
//   GID  2 B  output wire id
//   Frame lengths: BUF 5, XOR 7, AND 55 bytes.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset
//   in_valid    descriptor valid
//   in_ready    encoder idle, descriptor accepted on in_valid & in_ready
//   in_type     0=AND 1=XOR 2=BUF 3=invalid
//   in_id_1     first input wire id
//   in_id_2     second input wire id (ignored for BUF)
//   in_ctxt     ciphertext rows 1..N_CTXT, row k at [(k-1)*CTXT_W +: CTXT_W]
//   in_gate_id  output wire id
//   out_data    stream byte
//   out_valid   out_data valid
//   out_ready   sink accepts the current byte
//   out_first   current byte is the frame header
//   out_last    current byte is the final gate-id byte
//   busy        frame in progress
//   err         one-cycle pulse after an invalid-type descriptor is accepted
// -----------------------------------------------------------------------------
module gate_encoder #(
    parameter int ID_W   = 13,
    parameter int CTXT_W = 128,
    parameter int N_CTXT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_type,
    input  logic [ID_W-1:0]          in_id_1,
    input  logic [ID_W-1:0]          in_id_2,
    input  logic [N_CTXT*CTXT_W-1:0] in_ctxt,
    input  logic [ID_W-1:0]          in_gate_id,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_first,
    output logic                     out_last,
    output logic                     busy,
    output logic                     err
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int ID_BYTES   = (ID_W + 7) / 8;
    localparam int ID_PW      = ID_BYTES * 8;
    localparam int CTXT_BYTES = CTXT_W / 8;
    localparam int CTXT_TOTAL = N_CTXT * CTXT_BYTES;

    localparam logic [5:0] ID_LAST   = 6'(ID_BYTES - 1);
    localparam logic [5:0] CTXT_LAST = 6'(CTXT_TOTAL - 1);

    localparam logic [1:0] TYPE_AND = 2'd0;
    localparam logic [1:0] TYPE_XOR = 2'd1;
    localparam logic [1:0] TYPE_BUF = 2'd2;
    localparam logic [1:0] TYPE_INV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ID1,
        ST_ID2,
        ST_CTXT,
        ST_GID
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                   state_q, state_d;
    logic [5:0]               cnt_q, cnt_d;

    logic [1:0]               type_q, type_d;
    logic [ID_W-1:0]          id1_q, id1_d;
    logic [ID_W-1:0]          id2_q, id2_d;
    logic [N_CTXT*CTXT_W-1:0] ctxt_q, ctxt_d;
    logic [ID_W-1:0]          gid_q, gid_d;

    logic [7:0]               out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_first_q, out_first_d;
    logic                     out_last_q, out_last_d;
    logic                     err_q, err_d;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    logic accept;
    logic advance;

    assign accept  = in_valid && (state_q == ST_IDLE);
    assign advance = out_valid_q && out_ready;

    // Ids zero-extended to whole bytes so pad bits go out as zero.
    logic [ID_PW-1:0] id1_pad;
    logic [ID_PW-1:0] id2_pad;
    logic [ID_PW-1:0] gid_pad;

    assign id1_pad = ID_PW'(id1_q);
    assign id2_pad = ID_PW'(id2_q);
    assign gid_pad = ID_PW'(gid_q);

    // -------------------------------------------------------------------------
    // Next frame position: where (field, byte index) the stream moves to when
    // the byte currently presented is taken by the sink.
    // -------------------------------------------------------------------------
    state_t     nxt_state;
    logic [5:0] nxt_cnt;

    // NOTE: every signal driven by an always_comb gets a default at the top of
    // the block; any path that would otherwise leave it unassigned would infer
    // a latch.
    always_comb begin
        nxt_state = state_q;
        nxt_cnt   = cnt_q + 6'd1;

        case (state_q)
            ST_HDR: begin
                nxt_state = ST_ID1;
                nxt_cnt   = 6'd0;
            end
            ST_ID1: begin
                if (cnt_q == ID_LAST) begin
                    nxt_cnt   = 6'd0;
                    // BUF has a single input, so ID2 is skipped entirely.
                    nxt_state = (type_q == TYPE_BUF) ? ST_GID : ST_ID2;
                end
            end
            ST_ID2: begin
                if (cnt_q == ID_LAST) begin
                    nxt_cnt   = 6'd0;
                    // Only AND carries a garbled table; XOR is free.
                    nxt_state = (type_q == TYPE_AND) ? ST_CTXT : ST_GID;
                end
            end
            ST_CTXT: begin
                if (cnt_q == CTXT_LAST) begin
                    nxt_cnt   = 6'd0;
                    nxt_state = ST_GID;
                end
            end
            ST_GID: begin
                if (cnt_q == ID_LAST) begin
                    nxt_cnt   = 6'd0;
                    nxt_state = ST_IDLE;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = 6'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Byte at the next frame position.
    // Rows are packed contiguously with row 1 lowest, so the flat ciphertext
    // byte counter (row = cnt/16, byte = cnt%16) indexes the vector directly.
    // -------------------------------------------------------------------------
    logic [7:0] nxt_byte;

    always_comb begin
        nxt_byte = 8'h00;
        case (nxt_state)
            ST_ID1:  nxt_byte = id1_pad[int'(nxt_cnt) * 8 +: 8];
            ST_ID2:  nxt_byte = id2_pad[int'(nxt_cnt) * 8 +: 8];
            ST_CTXT: nxt_byte = ctxt_q[int'(nxt_cnt) * 8 +: 8];
            ST_GID:  nxt_byte = gid_pad[int'(nxt_cnt) * 8 +: 8];
            default: nxt_byte = 8'h00;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state / output register logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        type_d      = type_q;
        id1_d       = id1_q;
        id2_d       = id2_q;
        ctxt_d      = ctxt_q;
        gid_d       = gid_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;

        // Descriptor is captured on every accept so the inputs are free to
        // change afterwards.
        if (accept) begin
            type_d = in_type;
            id1_d  = in_id_1;
            id2_d  = in_id_2;
            ctxt_d = in_ctxt;
            gid_d  = in_gate_id;
        end

        if (state_q == ST_IDLE) begin
            if (accept) begin
                if (in_type == TYPE_INV) begin
                    // Swallowed: flag it and stay idle without emitting bytes.
                    err_d = 1'b1;
                end else begin
                    state_d     = ST_HDR;
                    cnt_d       = 6'd0;
                    out_data_d  = {6'b0, in_type};
                    out_valid_d = 1'b1;
                    out_first_d = 1'b1;
                    out_last_d  = 1'b0;
                end
            end
        end else if (advance) begin
            state_d     = nxt_state;
            cnt_d       = nxt_cnt;
            out_first_d = 1'b0;
            if (nxt_state == ST_IDLE) begin
                // Frame done; the idle cycle that follows is the inter-frame
                // bubble.
                out_valid_d = 1'b0;
                out_data_d  = 8'h00;
                out_last_d  = 1'b0;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = nxt_byte;
                out_last_d  = (nxt_state == ST_GID) && (nxt_cnt == ID_LAST);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, whatever the order of
    // statements.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 6'd0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the descriptor holding registers are deliberately left without
    // reset: they are always written on accept before being read, and keeping
    // the wide ciphertext store off the reset tree lets it map to plain flops.
    always_ff @(posedge clk) begin
        type_q <= type_d;
        id1_q  <= id1_d;
        id2_q  <= id2_d;
        ctxt_q <= ctxt_d;
        gid_q  <= gid_d;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule
